// File: rtl/madhu_addsub_accum_if.sv
// Valid/ready operand and result bus for madhu_addsub_accum.
// The master drives operand beats and out_ready. The slave returns the registered result.
interface madhu_addsub_accum_if #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       mode;
  logic             sat;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] result;
  logic             carry;

  modport master (
    output in_valid, op_a, op_b, mode, sat, out_ready,
    input  in_ready, out_valid, result, carry
  );

  modport slave (
    input  in_valid, op_a, op_b, mode, sat, out_ready,
    output in_ready, out_valid, result, carry
  );
endinterface

// File: rtl/madhu_addsub_accum.sv
// Registered add/sub/accumulate tile with optional saturation and a one-entry output register.
// Optional overflow statistics counter: define MADHU_ACC_STATS_EN.
module madhu_addsub_accum #(
  parameter int WIDTH = 8,
  parameter int ACC_W = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  madhu_addsub_accum_if.slave  bus,
  output logic [ACC_W-1:0]     acc,
  output logic [7:0]           ovf_count
);

  if (ACC_W < WIDTH + 1) begin : g_bad_acc_w
    $error("madhu_addsub_accum: ACC_W must be >= WIDTH+1");
  end

  typedef enum logic [1:0] {
    MODE_ADD = 2'b00,
    MODE_SUB = 2'b01,
    MODE_ACC = 2'b10,
    MODE_CLR = 2'b11
  } mode_e;

  localparam logic [ACC_W-1:0] OPND_MAX = ACC_W'({WIDTH{1'b1}});

  mode_e            mode;
  logic             accept;
  logic             drain;
  logic [WIDTH:0]   sum_ab;
  logic [WIDTH-1:0] diff_ab;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] nxt_result;
  logic [ACC_W-1:0] nxt_acc;
  logic             nxt_carry;

  assign mode         = mode_e'(bus.mode);
  // Ready depends only on ena and the output register, never on in_valid.
  assign bus.in_ready = ena && (!bus.out_valid || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign drain        = bus.out_valid && bus.out_ready;

  assign sum_ab  = {1'b0, bus.op_a} + {1'b0, bus.op_b};
  assign diff_ab = bus.op_a - bus.op_b;
  assign acc_sum = {1'b0, acc} + (ACC_W + 1)'(bus.op_a) + (ACC_W + 1)'(bus.op_b);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_acc    = acc;
    case (mode)
      MODE_ADD: begin
        nxt_carry  = sum_ab[WIDTH];
        nxt_result = (bus.sat && nxt_carry) ? OPND_MAX : ACC_W'(sum_ab);
      end
      MODE_SUB: begin
        nxt_carry  = (bus.op_a < bus.op_b);
        nxt_result = (bus.sat && nxt_carry) ? '0 : ACC_W'(diff_ab);
      end
      MODE_ACC: begin
        nxt_carry  = acc_sum[ACC_W];
        nxt_acc    = (bus.sat && nxt_carry) ? '1 : acc_sum[ACC_W-1:0];
        nxt_result = nxt_acc;
      end
      MODE_CLR: begin
        nxt_acc = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.carry     <= 1'b0;
      acc           <= '0;
    end else if (accept) begin
      bus.out_valid <= 1'b1;
      bus.result    <= nxt_result;
      bus.carry     <= nxt_carry;
      acc           <= nxt_acc;
    end else if (drain) begin
      bus.out_valid <= 1'b0;
    end
  end

`ifdef MADHU_ACC_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= 8'd0;
    end else if (accept) begin
      if (mode == MODE_CLR)
        ovf_count <= 8'd0;
      else if (nxt_carry && (ovf_count != 8'hFF))
        ovf_count <= ovf_count + 8'd1;
    end
  end
`else
  assign ovf_count = 8'd0;
`endif

endmodule

// File: tb/tb_madhu_addsub_accum.sv
// Scenario bench for madhu_addsub_accum: per-feature tasks plus an in-order result scoreboard.
module tb_madhu_addsub_accum;
  localparam int WIDTH = 8;
  localparam int ACC_W = 12;

  typedef struct {
    logic [ACC_W-1:0] r;
    logic             c;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic [ACC_W-1:0] acc;
  logic [7:0]       ovf_count;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic [ACC_W-1:0] exp_acc;

  madhu_addsub_accum_if #(.WIDTH(WIDTH), .ACC_W(ACC_W)) bus ();

  madhu_addsub_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .bus       (bus),
    .acc       (acc),
    .ovf_count (ovf_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: pops the scoreboard on every drain, sampled mid low phase.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: result=%0d carry=%0b with empty queue", bus.result, bus.carry);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.r || bus.carry !== e.c) begin
          errors++;
          $display("FAIL sb_result: got %0d/%0b expected %0d/%0b", bus.result, bus.carry, e.r, e.c);
        end
      end
    end
  end

  task automatic send(input logic [1:0] m, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic s, input logic [ACC_W-1:0] er, input logic ec);
    int budget;
    budget = 0;
    @(negedge clk);
    bus.mode = m; bus.op_a = a; bus.op_b = b; bus.sat = s; bus.in_valid = 1'b1;
    #2;
    while (!bus.in_ready && budget < 50) begin
      @(negedge clk);
      #2;
      budget++;
    end
    if (!bus.in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      return;
    end
    sb.push_back('{r: er, c: ec});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    bus.op_a = '0; bus.op_b = '0; bus.mode = 2'b00; bus.sat = 1'b0;
    #12;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0 ||
        acc !== '0 || ovf_count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state: ov=%0b res=%0d c=%0b acc=%0d ovf=%0d expected all 0",
               bus.out_valid, bus.result, bus.carry, acc, ovf_count);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_ena0: in_ready=%0b expected 0", bus.in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1; ena = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_ena1: in_ready=%0b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL add_pre_valid: out_valid=%0b expected 0", bus.out_valid);
    end
    send(2'b00, 8'd200, 8'd100, 1'b0, 12'd300, 1'b1);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 12'h12C || bus.carry !== 1'b1) begin
      errors++;
      $display("FAIL add_wrap: ov=%0b res=%0d c=%0b expected 1/300/1", bus.out_valid, bus.result, bus.carry);
    end
    send(2'b00, 8'd200, 8'd100, 1'b1, 12'd255, 1'b1);
    checks++;
    if (bus.result !== 12'd255 || bus.carry !== 1'b1 || acc !== '0) begin
      errors++;
      $display("FAIL add_sat: res=%0d c=%0b acc=%0d expected 255/1/0", bus.result, bus.carry, acc);
    end
  endtask

  task automatic test_sub();
    send(2'b01, 8'd5, 8'd10, 1'b0, 12'd251, 1'b1);
    checks++;
    if (bus.result !== 12'd251 || bus.carry !== 1'b1) begin
      errors++; $display("FAIL sub_borrow: res=%0d c=%0b expected 251/1", bus.result, bus.carry);
    end
    send(2'b01, 8'd10, 8'd5, 1'b1, 12'd5, 1'b0);
    checks++;
    if (bus.result !== 12'd5 || bus.carry !== 1'b0 || acc !== '0) begin
      errors++;
      $display("FAIL sub_plain: res=%0d c=%0b acc=%0d expected 5/0/0", bus.result, bus.carry, acc);
    end
    send(2'b01, 8'd3, 8'd9, 1'b1, 12'd0, 1'b1);
    checks++;
    if (bus.result !== 12'd0 || bus.carry !== 1'b1) begin
      errors++; $display("FAIL sub_sat: res=%0d c=%0b expected 0/1", bus.result, bus.carry);
    end
  endtask

  task automatic acc_run(input logic sat9, input logic [ACC_W-1:0] exp9);
    send(2'b11, 8'd77, 8'd33, 1'b0, 12'd0, 1'b0);
    checks++;
    if (acc !== '0) begin
      errors++; $display("FAIL acc_clr: acc=%0d expected 0", acc);
    end
    for (int i = 1; i <= 8; i++) begin
      send(2'b10, 8'd255, 8'd255, 1'b0, ACC_W'(i * 510), 1'b0);
      checks++;
      if (acc !== ACC_W'(i * 510) || bus.carry !== 1'b0) begin
        errors++;
        $display("FAIL acc_step%0d: acc=%0d c=%0b expected %0d/0", i, acc, bus.carry, i * 510);
      end
    end
    send(2'b10, 8'd255, 8'd255, sat9, exp9, 1'b1);
    checks++;
    if (acc !== exp9 || bus.result !== exp9 || bus.carry !== 1'b1) begin
      errors++;
      $display("FAIL acc_ninth_sat%0b: acc=%0d res=%0d c=%0b expected %0d/%0d/1",
               sat9, acc, bus.result, bus.carry, exp9, exp9);
    end
  endtask

  task automatic test_acc();
    acc_run(1'b0, 12'd494);
    acc_run(1'b1, 12'd4095);
    exp_acc = 12'd4095;
  endtask

  task automatic test_back_to_back();
    idle(2);
    bus.out_ready = 1'b0;
    send(2'b00, 8'd1, 8'd2, 1'b0, 12'd3, 1'b0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 12'd3 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_first: ov=%0b res=%0d rdy=%0b expected 1/3/0", bus.out_valid, bus.result, bus.in_ready);
    end
    @(negedge clk);
    bus.op_a = 8'd3; bus.op_b = 8'd4; bus.mode = 2'b00; bus.sat = 1'b0; bus.in_valid = 1'b1;
    repeat (3) begin
      #2;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.result !== 12'd3 || bus.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: rdy=%0b res=%0d ov=%0b expected 0/3/1", bus.in_ready, bus.result, bus.out_valid);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #2;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release: in_ready=%0b expected 1", bus.in_ready);
    end
    sb.push_back('{r: 12'd7, c: 1'b0});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== 12'd7 || acc !== exp_acc) begin
      errors++;
      $display("FAIL bp_drain_accept: ov=%0b res=%0d acc=%0d expected 1/7/%0d",
               bus.out_valid, bus.result, acc, exp_acc);
    end
    idle(2);
  endtask

  task automatic test_ena_and_reset();
    bus.out_ready = 1'b0;
    send(2'b00, 8'd9, 8'd9, 1'b0, 12'd18, 1'b0);
    @(negedge clk);
    ena = 1'b0;
    bus.op_a = 8'd1; bus.op_b = 8'd1; bus.mode = 2'b10; bus.sat = 1'b0; bus.in_valid = 1'b1;
    repeat (2) begin
      #2;
      checks++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.result !== 12'd18) begin
        errors++;
        $display("FAIL ena_block: rdy=%0b ov=%0b res=%0d expected 0/1/18", bus.in_ready, bus.out_valid, bus.result);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || acc !== exp_acc || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ena_drain: ov=%0b acc=%0d rdy=%0b expected 0/%0d/0", bus.out_valid, acc, bus.in_ready, exp_acc);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    bus.out_ready = 1'b0;
    send(2'b00, 8'd20, 8'd30, 1'b0, 12'd50, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0 || acc !== '0) begin
      errors++;
      $display("FAIL async_reset: ov=%0b res=%0d c=%0b acc=%0d expected all 0",
               bus.out_valid, bus.result, bus.carry, acc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #2;
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++; $display("FAIL post_reset_valid: out_valid=%0b expected 0", bus.out_valid);
      end
    end
  endtask

  task automatic test_stats();
`ifdef MADHU_ACC_STATS_EN
    send(2'b11, 8'd0, 8'd0, 1'b0, 12'd0, 1'b0);
    repeat (3) send(2'b00, 8'd200, 8'd100, 1'b0, 12'd300, 1'b1);
    checks++;
    if (ovf_count !== 8'd3) begin
      errors++; $display("FAIL ovf_three: ovf_count=%0d expected 3", ovf_count);
    end
    send(2'b11, 8'd0, 8'd0, 1'b0, 12'd0, 1'b0);
    checks++;
    if (ovf_count !== 8'd0) begin
      errors++; $display("FAIL ovf_clr: ovf_count=%0d expected 0", ovf_count);
    end
    repeat (300) send(2'b01, 8'd1, 8'd2, 1'b0, 12'd255, 1'b1);
    checks++;
    if (ovf_count !== 8'd255) begin
      errors++; $display("FAIL ovf_saturate: ovf_count=%0d expected 255", ovf_count);
    end
`else
    repeat (3) send(2'b00, 8'd200, 8'd100, 1'b0, 12'd300, 1'b1);
    checks++;
    if (ovf_count !== 8'd0) begin
      errors++; $display("FAIL ovf_disabled: ovf_count=%0d expected 0", ovf_count);
    end
`endif
  endtask

  initial begin
    exp_acc = '0;
    test_reset();
    test_add();
    test_sub();
    test_acc();
    test_back_to_back();
    test_ena_and_reset();
    test_stats();
    idle(3);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: %0d results never drained, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
